// File: rtl/param_datapath.sv
// Multi-cycle register-file datapath: a single shared bus feeds an ALU through Y/Z
// staging registers, with HI/LO result registers for the full-width product.
module param_datapath #(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [REGW-1:0]  ra,
    input  logic [REGW-1:0]  rb,
    input  logic [REGW-1:0]  rc,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    input  logic [REGW-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam int NREGS = 2**REGW;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_MFHI = 3'b101;
    localparam logic [2:0] OP_MFLO = 3'b110;
    localparam logic [2:0] OP_LDI  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [REGW-1:0]    ra_q, ra_d;
    logic [REGW-1:0]    rb_q, rb_d;
    logic [REGW-1:0]    rc_q, rc_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [WIDTH-1:0]   bus_s;

    // Non-product results are zero-extended into the double-width Z register.
    function automatic logic [2*WIDTH-1:0] alu(input logic [2:0] f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] zero_w;
        zero_w = {WIDTH{1'b0}};
        case (f)
            OP_ADD:  alu = {zero_w, a + b};
            OP_SUB:  alu = {zero_w, a - b};
            OP_AND:  alu = {zero_w, a & b};
            OP_OR:   alu = {zero_w, a | b};
            OP_MUL:  alu = {zero_w, a} * {zero_w, b};
            default: alu = {zero_w, b};
        endcase
    endfunction

    // State register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: MUL takes an extra cycle to write HI.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_T1;
                else       state_d = ST_IDLE;
            end
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op_q == OP_MUL) state_d = ST_T4;
                else                state_d = ST_IDLE;
            end
            ST_T4:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: done pulses on the cycle after the final write edge.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done_d = 1'b0;
        if ((state_q == ST_T3 && op_q != OP_MUL) || state_q == ST_T4) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath next values: command capture, bus steering, ALU and write-back.
    always_comb begin
        op_d   = op_q;
        ra_d   = ra_q;
        rb_d   = rb_q;
        rc_d   = rc_q;
        imm_d  = imm_q;
        y_d    = y_q;
        z_d    = z_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        regs_d = regs_q;
        bus_s  = {WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    ra_d  = ra;
                    rb_d  = rb;
                    rc_d  = rc;
                    imm_d = imm;
                end else begin
                    op_d  = op_q;
                end
            end
            ST_T1: begin
                bus_s = regs_q[rb_q];
                y_d   = bus_s;
            end
            ST_T2: begin
                case (op_q)
                    OP_LDI:  bus_s = imm_q;
                    OP_MFHI: bus_s = hi_q;
                    OP_MFLO: bus_s = lo_q;
                    default: bus_s = regs_q[rc_q];
                endcase
                z_d = alu(op_q, y_q, bus_s);
            end
            ST_T3: begin
                if (op_q == OP_MUL) lo_d = z_q[WIDTH-1:0];
                else                regs_d[ra_q] = z_q[WIDTH-1:0];
            end
            ST_T4:   hi_d = z_q[2*WIDTH-1:WIDTH];
            default: bus_s = {WIDTH{1'b0}};
        endcase
    end

    // Datapath registers, all cleared asynchronously so an aborted command leaves nothing behind.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q   <= 3'b000;
            ra_q   <= {REGW{1'b0}};
            rb_q   <= {REGW{1'b0}};
            rc_q   <= {REGW{1'b0}};
            imm_q  <= {WIDTH{1'b0}};
            y_q    <= {WIDTH{1'b0}};
            z_q    <= {(2*WIDTH){1'b0}};
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            done_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            op_q   <= op_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            rc_q   <= rc_d;
            imm_q  <= imm_d;
            y_q    <= y_d;
            z_q    <= z_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            regs_q <= regs_d;
        end
    end

    assign done    = done_q;
    assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_param_datapath.sv
// Randomized self-checking bench for param_datapath against an instruction-level model.
module tb_param_datapath;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] MUL = 3'b100, MFHI = 3'b101, MFLO = 3'b110, LDI = 3'b111;

    logic        clock = 1'b0;
    logic        clear;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [3:0]  ra = 4'd0, rb = 4'd0, rc = 4'd0, rd_addr = 4'd0;
    logic [31:0] imm = 32'd0;
    logic        busy, done;
    logic [31:0] rd_data, hi_q, lo_q;

    logic        s_start = 1'b0;
    logic [2:0]  s_op = 3'b000;
    logic [2:0]  s_ra = 3'd0, s_rb = 3'd0, s_rc = 3'd0, s_rd_addr = 3'd0;
    logic [7:0]  s_imm = 8'd0;
    logic        s_busy, s_done;
    logic [7:0]  s_rd_data, s_hi, s_lo;

    int checks = 0;
    int failures = 0;

    // Instruction-level reference state.
    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo;

    param_datapath #(.WIDTH(32), .REGW(4)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .imm(imm), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .hi_q(hi_q), .lo_q(lo_q)
    );

    param_datapath #(.WIDTH(8), .REGW(3)) dut_small (
        .clock(clock), .clear(clear), .start(s_start), .op(s_op), .ra(s_ra), .rb(s_rb),
        .rc(s_rc), .imm(s_imm), .busy(s_busy), .done(s_done), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .hi_q(s_hi), .lo_q(s_lo)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic model_exec(input logic [2:0] o, input logic [3:0] a, b, c, input logic [31:0] i);
        logic [63:0] p;
        case (o)
            ADD:  m_r[a] = m_r[b] + m_r[c];
            SUB:  m_r[a] = m_r[b] - m_r[c];
            AND_: m_r[a] = m_r[b] & m_r[c];
            OR_:  m_r[a] = m_r[b] | m_r[c];
            MUL: begin
                p = 64'(m_r[b]) * 64'(m_r[c]);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MFHI: m_r[a] = m_hi;
            MFLO: m_r[a] = m_lo;
            default: m_r[a] = i;
        endcase
    endtask

    // Launch one command from IDLE, scramble the inputs afterwards, and measure latency to done.
    task automatic issue(input logic [2:0] o, input logic [3:0] a, b, c, input logic [31:0] i,
                         output int lat);
        int cnt;
        @(negedge clock);
        op = o; ra = a; rb = b; rc = c; imm = i; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        op = 3'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); imm = $urandom;
        cnt = 1;
        while (done !== 1'b1 && cnt < 12) begin
            @(negedge clock);
            cnt++;
        end
        lat = (done === 1'b1) ? cnt - 1 : -1;
        model_exec(o, a, b, c, i);
    endtask

    task automatic issue8(input logic [2:0] o, input logic [2:0] a, b, c, input logic [7:0] i,
                          output int lat);
        int cnt;
        @(negedge clock);
        s_op = o; s_ra = a; s_rb = b; s_rc = c; s_imm = i; s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        cnt = 1;
        while (s_done !== 1'b1 && cnt < 12) begin
            @(negedge clock);
            cnt++;
        end
        lat = (s_done === 1'b1) ? cnt - 1 : -1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        #3 clear = 1'b0;
        #4;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0", hi_q, lo_q); end
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k); #1;
            checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", k, rd_data); end
        end
        model_reset();
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic test_ldi_add();
        int lat;
        issue(LDI, 4'd3, 4'd0, 4'd0, 32'h0000_0005, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ldi3_latency got=%0d exp=3", lat); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%0b exp=0", done); end
        issue(LDI, 4'd4, 4'd0, 4'd0, 32'h0000_0007, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ldi4_latency got=%0d exp=3", lat); end
        issue(ADD, 4'd5, 4'd3, 4'd4, 32'd0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
        rd_addr = 4'd5; #1;
        checks++; if (rd_data !== 32'h0000_000C) begin failures++; $display("FAIL add_r5 got=%h exp=0000000c", rd_data); end
    endtask

    task automatic test_wrap();
        int lat;
        issue(LDI, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, lat);
        issue(LDI, 4'd2, 4'd0, 4'd0, 32'h0000_0001, lat);
        issue(ADD, 4'd6, 4'd1, 4'd2, 32'd0, lat);
        rd_addr = 4'd6; #1;
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL add_wrap got=%h exp=00000000", rd_data); end
        issue(SUB, 4'd7, 4'd2, 4'd1, 32'd0, lat);
        rd_addr = 4'd7; #1;
        checks++; if (rd_data !== 32'h2) begin failures++; $display("FAIL sub_wrap got=%h exp=00000002", rd_data); end
    endtask

    task automatic test_mul();
        int lat;
        issue(LDI, 4'd2, 4'd0, 4'd0, 32'h0000_0002, lat);
        issue(MUL, 4'd0, 4'd1, 4'd2, 32'd0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL mul_latency got=%0d exp=4", lat); end
        checks++; if (hi_q !== 32'h1) begin failures++; $display("FAIL mul_hi got=%h exp=00000001", hi_q); end
        checks++; if (lo_q !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_lo got=%h exp=fffffffe", lo_q); end
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k); #1;
            checks++; if (rd_data !== m_r[k]) begin failures++; $display("FAIL mul_regs_r%0d got=%h exp=%h", k, rd_data, m_r[k]); end
        end
        issue(MFHI, 4'd8, 4'd0, 4'd0, 32'd0, lat);
        rd_addr = 4'd8; #1;
        checks++; if (rd_data !== 32'h1) begin failures++; $display("FAIL mfhi_r8 got=%h exp=00000001", rd_data); end
    endtask

    task automatic test_logic();
        int lat;
        issue(LDI, 4'd9, 4'd0, 4'd0, 32'h0F0F_0F0F, lat);
        issue(AND_, 4'd9, 4'd9, 4'd9, 32'd0, lat);
        rd_addr = 4'd9; #1;
        checks++; if (rd_data !== 32'h0F0F_0F0F) begin failures++; $display("FAIL and_self got=%h exp=0f0f0f0f", rd_data); end
        issue(LDI, 4'd10, 4'd0, 4'd0, 32'hF000_0000, lat);
        issue(OR_, 4'd9, 4'd9, 4'd10, 32'd0, lat);
        rd_addr = 4'd9; #1;
        checks++; if (rd_data !== 32'hFF0F_0F0F) begin failures++; $display("FAIL or_r9 got=%h exp=ff0f0f0f", rd_data); end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] o;
        logic [3:0] a, b, c;
        logic [31:0] i;
        for (int k = 0; k < 16; k++) issue(LDI, 4'(k), 4'd0, 4'd0, $urandom, lat);
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); i = $urandom;
            issue(o, a, b, c, i, lat);
            checks++; if (lat !== ((o == MUL) ? 4 : 3)) begin failures++; $display("FAIL rand_latency n=%0d op=%0d got=%0d", n, o, lat); end
            rd_addr = a; #1;
            checks++; if (rd_data !== m_r[a]) begin failures++; $display("FAIL rand_reg n=%0d op=%0d r%0d got=%h exp=%h", n, o, a, rd_data, m_r[a]); end
            checks++; if (hi_q !== m_hi || lo_q !== m_lo) begin failures++; $display("FAIL rand_hilo n=%0d got=%h/%h exp=%h/%h", n, hi_q, lo_q, m_hi, m_lo); end
        end
    endtask

    task automatic test_busy_ignore();
        int dn = 0;
        @(negedge clock);
        op = LDI; ra = 4'd12; imm = 32'hAAAA_0001; start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
            op = LDI; ra = 4'd12; imm = 32'h5555_0000 + 32'(k); start = 1'b1;
        end
        @(negedge clock);
        if (done === 1'b1) dn++;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        model_exec(LDI, 4'd12, 4'd0, 4'd0, 32'hAAAA_0001);
        checks++; if (dn !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", dn); end
        rd_addr = 4'd12; #1;
        checks++; if (rd_data !== m_r[12]) begin failures++; $display("FAIL busy_ignore_r12 got=%h exp=%h", rd_data, m_r[12]); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic [31:0] v;
        v = $urandom;
        @(negedge clock);
        op = LDI; ra = 4'd13; imm = v; start = 1'b1;
        cnt = 1;
        @(negedge clock);
        while (done !== 1'b1 && cnt < 12) begin @(negedge clock); cnt++; end
        checks++; if (cnt - 1 !== 3) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=3", cnt - 1); end
        model_exec(LDI, 4'd13, 4'd0, 4'd0, v);
        op = ADD; ra = 4'd14; rb = 4'd13; rc = 4'd13;
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_immediate_busy got=%0b exp=1", busy); end
        cnt = 1;
        while (done !== 1'b1 && cnt < 12) begin @(negedge clock); cnt++; end
        checks++; if (cnt - 1 !== 3) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=3", cnt - 1); end
        model_exec(ADD, 4'd14, 4'd13, 4'd13, 32'd0);
        rd_addr = 4'd14; #1;
        checks++; if (rd_data !== m_r[14]) begin failures++; $display("FAIL b2b_r14 got=%h exp=%h", rd_data, m_r[14]); end
    endtask

    task automatic test_clear_mid();
        int lat;
        @(negedge clock);
        op = ADD; ra = 4'd5; rb = 4'd3; rc = 4'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL clear_ctrl got busy=%0b done=%0b exp=0/0", busy, done); end
        checks++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin failures++; $display("FAIL clear_hilo got=%h/%h exp=0", hi_q, lo_q); end
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k); #1;
            checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL clear_reg%0d got=%h exp=0", k, rd_data); end
        end
        model_reset();
        @(negedge clock);
        clear = 1'b1;
        repeat (4) @(negedge clock);
        rd_addr = 4'd5; #1;
        checks++; if (busy !== 1'b0 || rd_data !== 32'd0) begin failures++; $display("FAIL clear_no_writeback got busy=%0b r5=%h exp=0/0", busy, rd_data); end
        issue(LDI, 4'd5, 4'd0, 4'd0, 32'h0000_0077, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL after_clear_latency got=%0d exp=3", lat); end
        rd_addr = 4'd5; #1;
        checks++; if (rd_data !== 32'h77) begin failures++; $display("FAIL after_clear_r5 got=%h exp=00000077", rd_data); end
    endtask

    task automatic test_small();
        int lat;
        issue8(LDI, 3'd1, 3'd0, 3'd0, 8'hFF, lat);
        issue8(LDI, 3'd2, 3'd0, 3'd0, 8'h01, lat);
        issue8(ADD, 3'd3, 3'd1, 3'd2, 8'h00, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL small_add_latency got=%0d exp=3", lat); end
        s_rd_addr = 3'd3; #1;
        checks++; if (s_rd_data !== 8'h00) begin failures++; $display("FAIL small_add_wrap got=%h exp=00", s_rd_data); end
        issue8(MUL, 3'd0, 3'd1, 3'd1, 8'h00, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL small_mul_latency got=%0d exp=4", lat); end
        checks++; if (s_hi !== 8'hFE || s_lo !== 8'h01) begin failures++; $display("FAIL small_mul got=%h/%h exp=fe/01", s_hi, s_lo); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ldi_add();
        test_wrap();
        test_mul();
        test_logic();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_clear_mid();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning data/bus width in bits (minimum 4).
REQ-002 The module SHALL have parameter REGW, default 4, meaning register-address width; the register count is NREGS = 2**REGW.
REQ-003 The module SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1, command request, sampled only in IDLE.
REQ-006 The module SHALL have port op, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 MFHI, 110 MFLO, 111 LDI.
REQ-007 The module SHALL have ports ra, rb, rc, input, REGW each, meaning destination, first source and second source register.
REQ-008 The module SHALL have port imm, input, WIDTH, the LDI immediate.
REQ-009 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The module SHALL have port done, output, 1, registered one-cycle completion pulse.
REQ-011 The module SHALL have ports rd_addr (input, REGW) and rd_data (output, WIDTH), a combinational debug read port for the register file.
REQ-012 The module SHALL have ports hi_q and lo_q, output, WIDTH each, showing the HI and LO registers.

Function
REQ-013 On a clock edge in IDLE with start=1, the block SHALL latch op, ra, rb, rc and imm into command registers and go to T1; later changes on these inputs SHALL have no effect.
REQ-014 T1: bus = R[rb]; Y <= bus; next state T2.
REQ-015 T2: bus = R[rc], or imm for LDI, HI for MFHI, LO for MFLO.
REQ-016 T2: Z (2*WIDTH) <= ALU(Y, bus).
REQ-017 ALU results SHALL be: ADD/SUB mod 2**WIDTH, zero-extended; AND/OR bitwise; MUL the unsigned full 2*WIDTH product; LDI/MFHI/MFLO pass bus through.
REQ-018 T3: for MUL, LO <= Z[WIDTH-1:0], then go to T4.
REQ-019 T3: for all other ops, R[ra] <= Z[WIDTH-1:0], then return to IDLE.
REQ-020 T4: HI <= Z[2*WIDTH-1:WIDTH]; return to IDLE.
REQ-021 done SHALL go high for exactly the one cycle after the final write edge; it coincides with the first IDLE cycle, and the written value is already visible on rd_data/hi_q/lo_q.
REQ-022 Latency from the start-sampling edge to done high SHALL be 3 cycles for non-MUL ops and 4 cycles for MUL.
REQ-023 start while busy SHALL be ignored, with no queuing.
REQ-024 start asserted in the same cycle as done SHALL be accepted; back-to-back commands are allowed.
REQ-025 Because sources are captured in T1/T2 before write-back, ra equal to rb or rc SHALL yield the correct result computed from the old values.
REQ-026 MUL SHALL NOT modify any general register, and ra is ignored for MUL.
REQ-027 All NREGS registers SHALL be general-purpose and writable; there is no hardwired zero register.

Reset
REQ-028 When clear goes low, at any time including mid-command, the FSM SHALL go to IDLE and all registers (R[*], Y, Z, HI, LO, command registers, done) SHALL be 0 asynchronously.
REQ-029 While clear is low, outputs SHALL be busy=0, done=0, rd_data=0, hi_q=0, lo_q=0.
REQ-030 After clear is released, the first accepted start SHALL behave as in REQ-013..022, with no partial state from the interrupted command.

Verification
REQ-031 LDI R3,0x0000_0005 then LDI R4,0x0000_0007 then ADD R5,R3,R4 -> R5=0x0000_000C, with done 3 cycles after each start.
REQ-032 R1=0xFFFF_FFFF, R2=1: ADD R6,R1,R2 -> R6=0, wrap; SUB R7,R2,R1 -> R7=0x0000_0002.
REQ-033 R1=0xFFFF_FFFF, R2=0x0000_0002, MUL R1,R2 -> HI=0x0000_0001, LO=0xFFFF_FFFE, done 4 cycles after start, R0..R15 unchanged; then MFHI R8 -> R8=1.
REQ-034 R9=0x0F0F_0F0F, AND R9,R9,R9 -> R9 unchanged; OR R9,R9,R10 with R10=0xF000_0000 -> R9=0xFF0F_0F0F.
REQ-035 Pulse start repeatedly while busy -> exactly one command executes; start held high across done -> next command begins immediately.
REQ-036 Assert clear low during T2 of an ADD -> busy, done and all registers 0 immediately, no write-back; run a WIDTH=8, REGW=3 instance with ADD 0xFF+0x01 -> 0x00.
